// File: rtl/pc_seq_if.sv
// pc_seq_if: bundle between the decode/branch-compare logic (master) and the
// PC sequencer (slave).
//   master drives: en, op, cond, imm_b, imm_j, imm_i, rs1
//   slave drives : pc, pc_link, halted, misalign, redirect, taken_cnt
interface pc_seq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             en;
    logic [2:0]       op;
    logic             cond;
    logic [11:0]      imm_b;
    logic [19:0]      imm_j;
    logic [11:0]      imm_i;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_link;
    logic             halted;
    logic             misalign;
    logic             redirect;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output en, op, cond, imm_b, imm_j, imm_i, rs1,
        input  pc, pc_link, halted, misalign, redirect, taken_cnt
    );

    modport slave (
        input  en, op, cond, imm_b, imm_j, imm_i, rs1,
        output pc, pc_link, halted, misalign, redirect, taken_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: RV32I program-counter sequencer.
// Holds the architectural PC and picks the next PC each enabled cycle
// (sequential, conditional branch, JAL, JALR). Misaligned taken targets drop
// the core into FAULT, HALT requests into HALT; both are left only by reset.
// A one-cycle redirect pulse follows every taken transfer and a saturating
// counter tallies taken transfers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pc_seq_if.slave (control/immediates in, PC and status out)
module pc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16,
    parameter int              ALLOW_C  = 0
) (
    input  logic       clk,
    input  logic       rst,
    pc_seq_if.slave    bus
);
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JAL  = 3'b010;
    localparam logic [2:0] OP_JALR = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             redirect_q, redirect_d;

    logic [XLEN-1:0]  seq, br_t, jal_t, jalr_sum, jalr_t, target;
    logic             taken, misaligned;

    // Immediates arrive as raw fields; the implicit low zero of B/J is
    // appended here instead of shifting.
    assign seq      = pc_q + XLEN'(4);
    assign br_t     = pc_q + {{(XLEN-13){bus.imm_b[11]}}, bus.imm_b, 1'b0};
    assign jal_t    = pc_q + {{(XLEN-21){bus.imm_j[19]}}, bus.imm_j, 1'b0};
    assign jalr_sum = bus.rs1 + {{(XLEN-12){bus.imm_i[11]}}, bus.imm_i};
    assign jalr_t   = {jalr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        taken  = 1'b0;
        target = seq;
        case (bus.op)
            OP_BR:   begin taken = bus.cond; target = br_t;   end
            OP_JAL:  begin taken = 1'b1;     target = jal_t;  end
            OP_JALR: begin taken = 1'b1;     target = jalr_t; end
            default: ;
        endcase
    end

    // Bit 0 is always clear on every target, so only bit 1 can misalign.
    assign misaligned = (ALLOW_C == 0) && target[1];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        if (state_q == S_RUN && bus.en) begin
            if (bus.op == OP_HALT) begin
                state_d = S_HALT;
            end else if (!taken) begin
                pc_d = seq;
            end else if (misaligned) begin
                state_d = S_FAULT;
            end else begin
                pc_d       = target;
                redirect_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_link   = seq;
    assign bus.halted    = (state_q != S_RUN);
    assign bus.misalign  = (state_q == S_FAULT);
    assign bus.redirect  = redirect_q;
    assign bus.taken_cnt = cnt_q;
endmodule
